// File: rtl/ray_monitor_pkg.sv
// Purpose : shared FSM state encoding for the ray monitor.
// Contents: STATE_W (state width) and the four state constants.
package ray_monitor_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_INSIDE  = 2'd1;
    localparam logic [STATE_W-1:0] ST_PENDING = 2'd2;
    localparam logic [STATE_W-1:0] ST_ALARM   = 2'd3;

endpackage

// File: rtl/block_averager.sv
// Purpose : block average of 2^AVG_LOG2 accepted ray samples.
// Ports   : clk, reset (async active-low), r / r_valid / enable (sample in),
//           r_avg (latest truncated average), r_avg_valid (one-cycle pulse).
module block_averager #(
    parameter int unsigned RAY_WIDTH = 8,
    parameter int unsigned AVG_LOG2  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RAY_WIDTH-1:0] r,
    input  logic                 r_valid,
    input  logic                 enable,
    output logic [RAY_WIDTH-1:0] r_avg,
    output logic                 r_avg_valid
);

    localparam int unsigned ACC_W = RAY_WIDTH + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_avg_full;

    assign w_accept   = r_valid & enable;
    assign w_last     = (r_cnt == CNT_LAST);
    // Includes the current sample so the last one of a block is never lost.
    assign w_sum      = r_acc + ACC_W'(r);
    assign w_avg_full = w_sum >> AVG_LOG2;

    // Accumulate; on the last sample publish the average and restart the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (!enable) begin
                // Disabled: drop the partial block, keep the last average.
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_avg       <= RAY_WIDTH'(w_avg_full);
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ray_monitor.sv
// Purpose : trap-escape monitor: block-averages ray magnitude, applies
//           hysteresis thresholds with debounce and raises a latched alarm.
// Ports   : clk, reset (async active-low); r, r_valid, enable; threshold_hi,
//           threshold_lo, debounce_count, clear_alarm; outputs r_avg,
//           r_avg_valid, alarm, state, peak.
// Config  : define RAY_MONITOR_PEAK_EN to build the peak-hold register;
//           otherwise peak is tied to 0.
module ray_monitor
    import ray_monitor_pkg::*;
#(
    parameter int unsigned RAY_WIDTH      = 8,
    parameter int unsigned RAY_FRAC_WIDTH = 4,
    parameter int unsigned AVG_LOG2       = 4,
    parameter int unsigned DEBOUNCE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [RAY_WIDTH-1:0]      r,
    input  logic                      r_valid,
    input  logic                      enable,
    input  logic [RAY_WIDTH-1:0]      threshold_hi,
    input  logic [RAY_WIDTH-1:0]      threshold_lo,
    input  logic [DEBOUNCE_WIDTH-1:0] debounce_count,
    input  logic                      clear_alarm,
    output logic [RAY_WIDTH-1:0]      r_avg,
    output logic                      r_avg_valid,
    output logic                      alarm,
    output logic [STATE_W-1:0]        state,
    output logic [RAY_WIDTH-1:0]      peak
);

    // Fixed-point format is pass-through; only sanity-check it.
    if (RAY_FRAC_WIDTH > RAY_WIDTH) begin : g_frac_chk
        $error("RAY_FRAC_WIDTH exceeds RAY_WIDTH");
    end

    logic [STATE_W-1:0]        r_state;
    logic [STATE_W-1:0]        w_state_nxt;
    logic [DEBOUNCE_WIDTH-1:0] r_dbc;
    logic [DEBOUNCE_WIDTH-1:0] w_dbc_nxt;
    logic [DEBOUNCE_WIDTH-1:0] w_dbc_eff;
    logic [DEBOUNCE_WIDTH-1:0] w_dbc_inc;
    logic                      r_alarm;
    logic                      w_over;
    logic                      w_clear_ok;

    block_averager #(
        .RAY_WIDTH (RAY_WIDTH),
        .AVG_LOG2  (AVG_LOG2)
    ) u_avg (
        .clk         (clk),
        .reset       (reset),
        .r           (r),
        .r_valid     (r_valid),
        .enable      (enable),
        .r_avg       (r_avg),
        .r_avg_valid (r_avg_valid)
    );

    // A debounce of 0 is treated as 1.
    assign w_dbc_eff  = (debounce_count == '0) ? DEBOUNCE_WIDTH'(1) : debounce_count;
    assign w_dbc_inc  = r_dbc + DEBOUNCE_WIDTH'(1);
    // Equality with threshold_hi counts as inside.
    assign w_over     = (r_avg > threshold_hi);
    // Clear is judged against the average currently on the output.
    assign w_clear_ok = enable && (r_state == ST_ALARM) && clear_alarm
                        && (r_avg <= threshold_lo);

    // State, debounce counter and alarm registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dbc   <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dbc   <= w_dbc_nxt;
            r_alarm <= (w_state_nxt == ST_ALARM);
        end
    end

    // Next-state logic; thresholds only act on a fresh average.
    always_comb begin
        w_state_nxt = r_state;
        w_dbc_nxt   = r_dbc;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_dbc_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_INSIDE;
                    w_dbc_nxt   = '0;
                end
                ST_INSIDE: begin
                    if (r_avg_valid && w_over) begin
                        w_dbc_nxt   = DEBOUNCE_WIDTH'(1);
                        w_state_nxt = (w_dbc_eff == DEBOUNCE_WIDTH'(1)) ? ST_ALARM : ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (r_avg_valid) begin
                        if (w_over) begin
                            w_dbc_nxt = w_dbc_inc;
                            if (w_dbc_inc >= w_dbc_eff) begin
                                w_state_nxt = ST_ALARM;
                            end
                        end else begin
                            w_dbc_nxt   = '0;
                            w_state_nxt = ST_INSIDE;
                        end
                    end
                end
                ST_ALARM: begin
                    if (w_clear_ok) begin
                        w_state_nxt = ST_INSIDE;
                        w_dbc_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_dbc_nxt   = '0;
                end
            endcase
        end
    end

    assign state = r_state;
    assign alarm = r_alarm;

`ifdef RAY_MONITOR_PEAK_EN
    logic [RAY_WIDTH-1:0] r_peak;
    logic                 w_accept;
    logic                 w_restart;

    assign w_accept  = r_valid & enable;
    // Fresh start on enable rising (IDLE with enable high) or an accepted clear.
    assign w_restart = ((r_state == ST_IDLE) && enable) || w_clear_ok;

    // Peak hold of accepted raw samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_peak <= '0;
        end else if (w_restart) begin
            r_peak <= w_accept ? r : '0;
        end else if (w_accept && (r > r_peak)) begin
            r_peak <= r;
        end
    end

    assign peak = r_peak;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_ray_monitor.sv
// Purpose : self-checking bench for ray_monitor (RAY_WIDTH=8, AVG_LOG2=2).
module tb_ray_monitor;

`ifdef RAY_MONITOR_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0, S_IN = 2'd1, S_PEND = 2'd2, S_ALM = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] r;
    logic       r_valid;
    logic       enable;
    logic [7:0] threshold_hi;
    logic [7:0] threshold_lo;
    logic [7:0] debounce_count;
    logic       clear_alarm;
    logic [7:0] r_avg;
    logic       r_avg_valid;
    logic       alarm;
    logic [1:0] state;
    logic [7:0] peak;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ray_monitor #(
        .RAY_WIDTH      (8),
        .RAY_FRAC_WIDTH (4),
        .AVG_LOG2       (2),
        .DEBOUNCE_WIDTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .r              (r),
        .r_valid        (r_valid),
        .enable         (enable),
        .threshold_hi   (threshold_hi),
        .threshold_lo   (threshold_lo),
        .debounce_count (debounce_count),
        .clear_alarm    (clear_alarm),
        .r_avg          (r_avg),
        .r_avg_valid    (r_avg_valid),
        .alarm          (alarm),
        .state          (state),
        .peak           (peak)
    );

    typedef struct {
        logic [7:0] r;
        logic       valid;
        logic       en;
        logic       clr;
        logic [7:0] exp_avg;
        logic       exp_v;
        logic [1:0] exp_st;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] last_avg = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_avg, input logic e_v,
                              input logic [1:0] e_st);
        check({tag, " r_avg"},       32'(r_avg),       32'(e_avg));
        check({tag, " r_avg_valid"}, 32'(r_avg_valid), 32'(e_v));
        check({tag, " state"},       32'(state),       32'(e_st));
        check({tag, " alarm"},       32'(alarm),       32'(e_st == S_ALM));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] rv, input logic v, input logic en, input logic clr);
        r = rv; r_valid = v; enable = en; clear_alarm = clr;
    endtask

    task automatic add_row(input logic [7:0] rv, input logic v, input logic en, input logic clr,
                           input logic [7:0] e_avg, input logic e_v, input logic [1:0] e_st);
        vec_t t;
        t.r = rv; t.valid = v; t.en = en; t.clr = clr;
        t.exp_avg = e_avg; t.exp_v = e_v; t.exp_st = e_st;
        vecs.push_back(t);
        last_avg = e_avg;
    endtask

    // Four continuous samples; st_first is the state after the first one.
    task automatic add_block(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [7:0] avg,
                             input logic [1:0] st_first, input logic [1:0] st_rest,
                             input logic clr_last);
        logic [7:0] prev;
        prev = last_avg;
        add_row(a, 1'b1, 1'b1, 1'b0, prev, 1'b0, st_first);
        add_row(b, 1'b1, 1'b1, 1'b0, prev, 1'b0, st_rest);
        add_row(c, 1'b1, 1'b1, 1'b0, prev, 1'b0, st_rest);
        add_row(d, 1'b1, 1'b1, clr_last, avg, 1'b1, st_rest);
    endtask

    initial begin
        reset = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        threshold_hi   = 8'h30;
        threshold_lo   = 8'h25;
        debounce_count = 8'd3;

        // Vector table
        add_row(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, S_IN);                    // enable rise
        add_block(8'h10, 8'h11, 8'h12, 8'h13, 8'h11, S_IN, S_IN, 1'b0);         // 0x46>>2
        add_row(8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, S_IN);
        add_block(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, S_IN, S_IN, 1'b0);
        add_block(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, S_PEND, S_PEND, 1'b0);
        add_block(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, S_PEND, S_PEND, 1'b0);
        add_row(8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0, S_ALM);                   // 3rd over avg
        add_block(8'h28, 8'h28, 8'h28, 8'h28, 8'h28, S_ALM, S_ALM, 1'b0);
        add_row(8'h00, 1'b0, 1'b1, 1'b1, 8'h28, 1'b0, S_ALM);                   // clear rejected
        add_block(8'h20, 8'h20, 8'h20, 8'h20, 8'h20, S_ALM, S_ALM, 1'b1);       // clear sees 0x28
        add_row(8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, S_IN);                    // clear with pulse
        add_block(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, S_IN, S_IN, 1'b0);
        add_block(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, S_PEND, S_PEND, 1'b0);
        add_block(8'h20, 8'h20, 8'h20, 8'h20, 8'h20, S_PEND, S_PEND, 1'b0);
        add_block(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, S_IN, S_IN, 1'b0);
        add_row(8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0, S_PEND);

        // Reset state
        step(); step();
        check_outs("reset", 8'h00, 1'b0, S_IDLE);
        check("reset peak", 32'(peak), 32'h0);
        reset = 1'b1;
        step();
        check_outs("post-reset idle", 8'h00, 1'b0, S_IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].valid, vecs[i].en, vecs[i].clr);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_avg, vecs[i].exp_v, vecs[i].exp_st);
        end

        // Enable drop mid-block, then fresh block
        drive(8'h50, 1'b1, 1'b1, 1'b0); step();
        drive(8'h50, 1'b1, 1'b1, 1'b0); step();
        check_outs("partial", 8'h40, 1'b0, S_PEND);
        drive(8'h00, 1'b0, 1'b0, 1'b0); step();
        check_outs("disabled", 8'h40, 1'b0, S_IDLE);
        drive(8'h00, 1'b0, 1'b1, 1'b0); step();
        check_outs("re-enable", 8'h40, 1'b0, S_IN);
        for (int i = 0; i < 3; i++) begin
            drive(8'h08, 1'b1, 1'b1, 1'b0); step();
            check_outs($sformatf("fresh%0d", i), 8'h40, 1'b0, S_IN);
        end
        drive(8'h08, 1'b1, 1'b1, 1'b0); step();
        check_outs("fresh avg", 8'h08, 1'b1, S_IN);

        // Peak hold and threshold equality
        drive(8'h00, 1'b0, 1'b0, 1'b0); step();
        drive(8'h00, 1'b0, 1'b1, 1'b0); step();
        check("peak restart", 32'(peak), 32'h0);
        drive(8'h12, 1'b1, 1'b1, 1'b0); step();
        drive(8'h7F, 1'b1, 1'b1, 1'b0); step();
        drive(8'h30, 1'b1, 1'b1, 1'b0); step();
        check("peak max", 32'(peak), PEAK_EN ? 32'h7F : 32'h0);
        drive(8'h01, 1'b1, 1'b1, 1'b0); step();
        check_outs("eq avg", 8'h30, 1'b1, S_IN);                                 // 0xC2>>2
        drive(8'h00, 1'b0, 1'b1, 1'b0); step();
        check_outs("eq inside", 8'h30, 1'b0, S_IN);

        // debounce_count=0 alarms on the first over average; async reset in ALARM
        debounce_count = 8'd0;
        drive(8'h00, 1'b0, 1'b0, 1'b0); step();
        drive(8'h00, 1'b0, 1'b1, 1'b0); step();
        for (int i = 0; i < 4; i++) begin
            drive(8'h50, 1'b1, 1'b1, 1'b0); step();
        end
        check_outs("dbc0 pulse", 8'h50, 1'b1, S_IN);
        drive(8'h50, 1'b1, 1'b1, 1'b0); step();
        check_outs("dbc0 alarm", 8'h50, 1'b0, S_ALM);
        drive(8'h50, 1'b1, 1'b1, 1'b0); step();
        check("alarm peak", 32'(peak), PEAK_EN ? 32'h50 : 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("async reset", 8'h00, 1'b0, S_IDLE);
        check("async reset peak", 32'(peak), 32'h0);
        drive(8'h60, 1'b1, 1'b1, 1'b0); step();
        check_outs("held reset", 8'h00, 1'b0, S_IDLE);
        reset = 1'b1;
        debounce_count = 8'd3;
        for (int i = 0; i < 3; i++) begin
            drive(8'h60, 1'b1, 1'b1, 1'b0); step();
            check_outs($sformatf("after reset%0d", i), 8'h00, 1'b0, S_IN);
        end
        drive(8'h60, 1'b1, 1'b1, 1'b0); step();
        check_outs("after reset avg", 8'h60, 1'b1, S_IN);
        check("after reset peak", 32'(peak), PEAK_EN ? 32'h60 : 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ray_monitor.md
RAY_MONITOR -- requirements
Module: ray_monitor

Interface
REQ-001 SHALL have parameter RAY_WIDTH, default 8, bit width of the unsigned ray input.
REQ-002 SHALL have parameter RAY_FRAC_WIDTH, default 4, fractional bits of the ray input; carried through unchanged to r_avg and peak.
REQ-003 SHALL have parameter AVG_LOG2, default 4, giving a block average of 2^AVG_LOG2 samples.
REQ-004 SHALL have parameter DEBOUNCE_WIDTH, default 8, the width of the debounce counter.
REQ-005 SHALL have these ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- r  in  RAY_WIDTH  unsigned ray magnitude from the upstream ray stage.
- r_valid  in  1  r is a new sample this cycle.
- enable  in  1  monitor enabled.
- threshold_hi  in  RAY_WIDTH  escape threshold.
- threshold_lo  in  RAY_WIDTH  re-arm threshold (hysteresis).
- debounce_count  in  DEBOUNCE_WIDTH  consecutive over-threshold averages required to alarm.
- clear_alarm  in  1  alarm acknowledge.
- r_avg  out  RAY_WIDTH  latest block average.
- r_avg_valid  out  1  one-cycle pulse when r_avg updates.
- alarm  out  1  trap-escape alarm.
- state  out  2  FSM state.
- peak  out  RAY_WIDTH  peak-hold value.

Function
REQ-006 SHALL accept a sample only on cycles where r_valid=1 and enable=1.
REQ-007 SHALL sum accepted samples in an accumulator RAY_WIDTH+AVG_LOG2 bits wide, with no overflow possible.
REQ-008 On the 2^AVG_LOG2-th accepted sample, SHALL register r_avg = sum>>AVG_LOG2 (truncated) and pulse r_avg_valid on the next cycle.
REQ-009 SHALL clear the accumulator and wrap the sample counter to 0 in that same cycle, with no lost samples when r_valid is held high.
REQ-010 SHALL provide FSM states IDLE=0, INSIDE=1, PENDING=2, ALARM=3, advanced only on r_avg_valid except where REQ-014 and REQ-016 say otherwise.
REQ-011 INSIDE: an average > threshold_hi SHALL load the debounce counter with 1 and go to PENDING; if debounce_count<=1, it SHALL go directly to ALARM.
REQ-012 PENDING: an average > threshold_hi SHALL increment the counter and go to ALARM when the counter reaches debounce_count; an average <= threshold_hi SHALL clear the counter and return to INSIDE.
REQ-013 debounce_count=0 SHALL behave as 1.
REQ-014 ALARM SHALL latch; clear_alarm=1 while the current r_avg <= threshold_lo SHALL go to INSIDE; otherwise ALARM SHALL persist.
REQ-015 If clear_alarm and r_avg_valid coincide, SHALL compare against the newly registered average (one cycle later), i.e. a clear is evaluated on the r_avg present at the output.
REQ-016 enable=0 SHALL force IDLE from any state within one cycle, clear the accumulator, counters and alarm, and hold r_avg; enable rising SHALL go IDLE->INSIDE and start a fresh block.
REQ-017 alarm SHALL be 1 exactly when state==ALARM (registered, one cycle after the qualifying r_avg_valid).
REQ-018 Threshold equality (avg == threshold_hi) SHALL count as inside.

Reset
REQ-019 reset low SHALL asynchronously clear the accumulator, sample and debounce counters, r_avg, r_avg_valid, alarm and peak to 0, and set state to IDLE.
REQ-020 Reset release mid-block SHALL discard partial sums, so the first average after release uses a full block.

Configuration
REQ-021 With RAY_MONITOR_PEAK_EN defined, peak SHALL hold the maximum accepted raw r, reset to 0 on reset, enable rising, and an accepted clear_alarm.
REQ-022 Without RAY_MONITOR_PEAK_EN, peak SHALL be constant 0 and no peak register SHALL exist.

Structure
REQ-023 Package ray_monitor_pkg SHALL hold the state encoding constants and the state width.
REQ-024 Sub-module block_averager SHALL implement REQ-006 to REQ-009 (accumulator, counter, r_avg/r_avg_valid); the FSM and peak hold SHALL stay in ray_monitor.

Verification
REQ-025 Benches SHALL use RAY_WIDTH=8 and AVG_LOG2=2 in the following scenarios.
REQ-026 Samples 0x10,0x11,0x12,0x13 with r_valid continuous -> r_avg=0x11 (truncation of 0x46>>2), r_avg_valid pulse one cycle after the 4th sample.
REQ-027 threshold_hi=0x30, debounce_count=3, three averages of 0x40 -> alarm=1 one cycle after the 3rd pulse; sequence 0x40,0x40,0x20,0x40 -> no alarm, state PENDING at the end.
REQ-028 In ALARM with threshold_lo=0x25: clear_alarm at r_avg=0x28 -> stays ALARM; after r_avg=0x20, clear_alarm -> INSIDE, alarm=0.
REQ-029 enable dropped after 2 samples, then re-raised -> state IDLE then INSIDE; next r_avg_valid only after 4 new samples.
REQ-030 reset asserted while in ALARM with peak=0x50 -> all outputs 0, state IDLE immediately (asynchronous), no pulse after release until a full block.
REQ-031 With RAY_MONITOR_PEAK_EN, samples 0x12,0x7F,0x30 -> peak=0x7F; without the macro -> peak=0.
